// File: rtl/gpio_arb_pkg.sv
// Shared encodings for the two-master GPIO register-port arbiter.
package gpio_arb_pkg;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } arb_state_e;

  localparam logic OWN_M0 = 1'b0;
  localparam logic OWN_M1 = 1'b1;

endpackage

// File: rtl/gpio_bus_arb_rr_arb2.sv
// Two-way winner select: round-robin on last_owner, or fixed m0 priority.
module rr_arb2
  import gpio_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  input  logic       rr,
  output logic [1:0] win
);

  always_comb begin
    win = 2'b00;
    case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11:   win = (rr && last_owner == OWN_M0) ? 2'b10 : 2'b01;
      default: win = 2'b00;
    endcase
  end

endmodule

// File: rtl/gpio_bus_arb.sv
// Shares one gpio_top4 register port between two single-beat req/gnt masters.
module gpio_bus_arb
  import gpio_arb_pkg::*;
#(
  parameter int DW = 32,
  parameter bit RR = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [1:0]    m0_addr,
  input  logic [DW-1:0] m0_wd,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [1:0]    m1_addr,
  input  logic [DW-1:0] m1_wd,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic [1:0]    gpio_A,
  output logic          gpio_WE,
  output logic [DW-1:0] gpio_WD,
  input  logic [DW-1:0] gpio_RD
);

  arb_state_e    state;
  logic          owner, last_owner;
  logic          we_q;
  logic [1:0]    addr_q;
  logic [DW-1:0] wd_q;
  logic [1:0]    win;
  logic          bus_en;

  rr_arb2 u_arb (
    .req       ({m1_req, m0_req}),
    .last_owner(last_owner),
    .rr        (RR),
    .win       (win)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      owner      <= OWN_M0;
      last_owner <= OWN_M1;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wd_q       <= '0;
      m0_gnt     <= 1'b0;
      m1_gnt     <= 1'b0;
      m0_rvalid  <= 1'b0;
      m1_rvalid  <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
    end else begin
      m0_gnt    <= 1'b0;
      m1_gnt    <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      if (state == S_IDLE) begin
        if (|win) begin
          owner      <= win[1] ? OWN_M1 : OWN_M0;
          last_owner <= win[1] ? OWN_M1 : OWN_M0;
          we_q       <= win[1] ? m1_we   : m0_we;
          addr_q     <= win[1] ? m1_addr : m0_addr;
          wd_q       <= win[1] ? m1_wd   : m0_wd;
          m0_gnt     <= win[0];
          m1_gnt     <= win[1];
          state      <= S_ACCESS;
        end
      end else begin
        // rdata only moves on reads; writes just get the rvalid acknowledge.
        if (owner == OWN_M0) begin
          m0_rvalid <= 1'b1;
          if (!we_q) m0_rdata <= gpio_RD;
        end else begin
          m1_rvalid <= 1'b1;
          if (!we_q) m1_rdata <= gpio_RD;
        end
        state <= S_IDLE;
      end
    end
  end

  // Port is gated by rst too, so a reset during ACCESS cannot commit a write.
  assign bus_en  = (state == S_ACCESS) && !rst;
  assign gpio_A  = bus_en ? addr_q : 2'b00;
  assign gpio_WE = bus_en ? we_q   : 1'b0;
  assign gpio_WD = bus_en ? wd_q   : '0;

endmodule

// File: tb/tb_gpio_bus_arb.sv
// Directed vector bench for gpio_bus_arb with a 4-register GPIO model per instance.
module tb_gpio_bus_arb;

  logic        clk = 1'b0;
  logic        rst, load;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [1:0]  m0_addr, m1_addr;
  logic [31:0] m0_wd, m1_wd;

  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, gpio_WE;
  logic [31:0] m0_rdata, m1_rdata, gpio_WD, gpio_RD;
  logic [1:0]  gpio_A;
  logic        f_m0_gnt, f_m0_rvalid, f_m1_gnt, f_m1_rvalid, f_WE;
  logic [31:0] f_m0_rdata, f_m1_rdata, f_WD, f_RD;
  logic [1:0]  f_A;

  logic [31:0] regs [4];
  logic [31:0] fregs[4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gpio_bus_arb #(.DW(32), .RR(1'b1)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wd(m0_wd),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wd(m1_wd),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .gpio_A(gpio_A), .gpio_WE(gpio_WE), .gpio_WD(gpio_WD), .gpio_RD(gpio_RD)
  );

  gpio_bus_arb #(.DW(32), .RR(1'b0)) dut_fp (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wd(m0_wd),
    .m0_gnt(f_m0_gnt), .m0_rvalid(f_m0_rvalid), .m0_rdata(f_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wd(m1_wd),
    .m1_gnt(f_m1_gnt), .m1_rvalid(f_m1_rvalid), .m1_rdata(f_m1_rdata),
    .gpio_A(f_A), .gpio_WE(f_WE), .gpio_WD(f_WD), .gpio_RD(f_RD)
  );

  assign gpio_RD = regs[gpio_A];
  assign f_RD    = fregs[f_A];

  always @(posedge clk) begin
    if (load) begin
      regs[0] <= 32'hDEAD_BEEF; regs[1] <= '0; regs[2] <= '0; regs[3] <= '0;
      fregs[0] <= 32'hDEAD_BEEF; fregs[1] <= '0; fregs[2] <= '0; fregs[3] <= '0;
    end else begin
      if (gpio_WE) regs[gpio_A] <= gpio_WD;
      if (f_WE)    fregs[f_A]   <= f_WD;
    end
  end

  typedef struct {
    logic        r0, we0; logic [1:0] a0; logic [31:0] wd0;
    logic        r1, we1; logic [1:0] a1; logic [31:0] wd1;
    logic        eg0, eg1, ev0, ev1;
    logic [1:0]  ea; logic ewe; logic [31:0] ewd, ed0, ed1;
  } vec_t;

  vec_t tv[11];

  function automatic vec_t mk(logic r0, logic we0, logic [1:0] a0, logic [31:0] wd0,
                              logic r1, logic we1, logic [1:0] a1, logic [31:0] wd1,
                              logic eg0, logic eg1, logic ev0, logic ev1,
                              logic [1:0] ea, logic ewe, logic [31:0] ewd,
                              logic [31:0] ed0, logic [31:0] ed1);
    vec_t v;
    v.r0 = r0; v.we0 = we0; v.a0 = a0; v.wd0 = wd0;
    v.r1 = r1; v.we1 = we1; v.a1 = a1; v.wd1 = wd1;
    v.eg0 = eg0; v.eg1 = eg1; v.ev0 = ev0; v.ev1 = ev1;
    v.ea = ea; v.ewe = ewe; v.ewd = ewd; v.ed0 = ed0; v.ed1 = ed1;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(logic r0, logic we0, logic [1:0] a0, logic [31:0] wd0,
                       logic r1, logic we1, logic [1:0] a1, logic [31:0] wd1);
    m0_req = r0; m0_we = we0; m0_addr = a0; m0_wd = wd0;
    m1_req = r1; m1_we = we1; m1_addr = a1; m1_wd = wd1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("rst_gnt", {m0_gnt, m1_gnt, f_m0_gnt, f_m1_gnt}, 0);
    chk("rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
    chk("rst_rdata", m0_rdata | m1_rdata, 0);
    chk("rst_bus", {gpio_A, gpio_WE} | gpio_WD, 0);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic g0, g1, p0, p1, exp_who;
    int n0, n1, ng, last_c;

    load = 1'b1;
    do_reset();
    load = 1'b0;

    //   m0: req we addr wd     m1: req we addr wd      gnt0/1 rv0/1  A WE WD   rdata0 rdata1
    tv[0]  = mk(1,0,0,0,           0,0,0,0,               1,0,0,0, 0,0,0,       0,            0);
    tv[1]  = mk(0,0,0,0,           0,0,0,0,               0,0,1,0, 0,0,0,       32'hDEAD_BEEF,0);
    tv[2]  = mk(0,0,0,0,           1,1,2,32'hA5,          0,1,0,0, 2,1,32'hA5,  32'hDEAD_BEEF,0);
    tv[3]  = mk(0,0,0,0,           0,0,0,0,               0,0,0,1, 0,0,0,       32'hDEAD_BEEF,0);
    tv[4]  = mk(0,0,0,0,           0,0,0,0,               0,0,0,0, 0,0,0,       32'hDEAD_BEEF,0);
    tv[5]  = mk(1,0,2,0,           1,1,2,32'h1234,        1,0,0,0, 2,0,0,       32'hDEAD_BEEF,0);
    tv[6]  = mk(0,0,0,0,           1,1,2,32'h1234,        0,0,1,0, 0,0,0,       32'hA5,       0);
    tv[7]  = mk(0,0,0,0,           1,1,2,32'h1234,        0,1,0,0, 2,1,32'h1234,32'hA5,       0);
    tv[8]  = mk(1,0,2,0,           0,0,0,0,               0,0,0,1, 0,0,0,       32'hA5,       0);
    tv[9]  = mk(1,0,2,0,           0,0,0,0,               1,0,0,0, 2,0,0,       32'hA5,       0);
    tv[10] = mk(0,0,0,0,           0,0,0,0,               0,0,1,0, 0,0,0,       32'h1234,     0);

    for (int i = 0; i < 11; i++) begin
      drive(tv[i].r0, tv[i].we0, tv[i].a0, tv[i].wd0, tv[i].r1, tv[i].we1, tv[i].a1, tv[i].wd1);
      @(negedge clk);
      chk($sformatf("v%0d_m0_gnt", i), m0_gnt, tv[i].eg0);
      chk($sformatf("v%0d_m1_gnt", i), m1_gnt, tv[i].eg1);
      chk($sformatf("v%0d_m0_rvalid", i), m0_rvalid, tv[i].ev0);
      chk($sformatf("v%0d_m1_rvalid", i), m1_rvalid, tv[i].ev1);
      chk($sformatf("v%0d_gpio_A", i), gpio_A, tv[i].ea);
      chk($sformatf("v%0d_gpio_WE", i), gpio_WE, tv[i].ewe);
      chk($sformatf("v%0d_gpio_WD", i), gpio_WD, tv[i].ewd);
      chk($sformatf("v%0d_m0_rdata", i), m0_rdata, tv[i].ed0);
      chk($sformatf("v%0d_m1_rdata", i), m1_rdata, tv[i].ed1);
      chk($sformatf("v%0d_fp_gnt", i), {f_m0_gnt, f_m1_gnt}, {tv[i].eg0, tv[i].eg1});
    end

    // Both request with m0 as last owner: round-robin picks m1, fixed priority m0.
    drive(1, 0, 0, 0, 1, 0, 1, 0);
    @(negedge clk);
    chk("rr_tie_after_m0", {m0_gnt, m1_gnt}, 2'b01);
    chk("fp_tie_after_m0", {f_m0_gnt, f_m1_gnt}, 2'b10);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);

    // Continuous requests, RR=1: strict alternation, one grant every 2 cycles.
    do_reset();
    drive(1, 0, 0, 0, 1, 0, 1, 0);
    p0 = 0; p1 = 0; n0 = 0; n1 = 0; ng = 0; last_c = -1; exp_who = 0;
    for (int c = 0; c < 40 && ng < 6; c++) begin
      @(negedge clk);
      g0 = m0_gnt; g1 = m1_gnt;
      chk("rr_single_gnt", {31'd0, g0 & g1}, 0);
      if (g0 || g1) begin
        chk($sformatf("rr_order_%0d", ng), g1, exp_who);
        if (last_c >= 0) chk("rr_spacing", c - last_c, 2);
        last_c = c; exp_who = ~exp_who; ng++;
        if (g0) n0++; else n1++;
      end
      m0_req = (n0 < 3) && !g0 && !p0; p0 = g0;
      m1_req = (n1 < 3) && !g1 && !p1; p1 = g1;
    end
    chk("rr_grant_count", ng, 6);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);

    // Reset lands in the ACCESS cycle of a write.
    do_reset();
    drive(1, 1, 3, 32'h55, 0, 0, 0, 0);
    @(negedge clk);
    chk("rsta_gnt", m0_gnt, 1);
    chk("rsta_we_pre", gpio_WE, 1);
    rst = 1'b1;
    #1;
    chk("rsta_we_forced", gpio_WE, 0);
    chk("rsta_bus_forced", {30'd0, gpio_A} | gpio_WD, 0);
    m0_req = 1'b0;
    @(negedge clk);
    chk("rsta_no_rvalid", {m0_rvalid, m1_rvalid}, 0);
    chk("rsta_no_write", regs[3], 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rsta_no_rvalid2", {m0_rvalid, m1_rvalid}, 0);

    // Next tie after reset goes to m0 in both modes; m1 follows.
    drive(1, 0, 3, 0, 1, 0, 0, 0);
    @(negedge clk);
    chk("post_rst_tie", {m0_gnt, m1_gnt}, 2'b10);
    chk("post_rst_tie_fp", {f_m0_gnt, f_m1_gnt}, 2'b10);
    m0_req = 1'b0;
    @(negedge clk);
    chk("post_rst_rvalid0", m0_rvalid, 1);
    chk("post_rst_rdata0", m0_rdata, 0);
    @(negedge clk);
    chk("post_rst_m1_gnt", {m0_gnt, m1_gnt}, 2'b01);
    m1_req = 1'b0;
    @(negedge clk);
    chk("post_rst_rvalid1", m1_rvalid, 1);
    chk("post_rst_rdata1", m1_rdata, 32'hDEAD_BEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
